hazard_scoreboard: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Tracks destination register and remaining result latency (Tnew) of in-flight instructions in E, M and W. Compares them against the D-stage source registers and their usage deadlines (Tuse). Produces the stall, which freezes PC/IF-ID and clears ID-EX, and the D-stage forwarding selects. It is the consumer side of the per-stage WriteAddr/Tnew bookkeeping carried by the pipeline registers.

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_src_check.sv | 37 +++
 rtl/hazard_scoreboard.sv | 78 +++++++
 tb/tb_hazard_scoreboard.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, entry layout and the saturating Tnew decrement for the
// hazard scoreboard. Register and Tnew/Tuse widths are fixed here for all files.
package hazard_scoreboard_pkg;

  localparam int NREG_W  = 5;
  localparam int T_W     = 2;
  localparam int ENTRY_W = NREG_W + T_W;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  // addr == 0 marks an empty slot ($0 is never a real destination).
  typedef struct packed {
    logic [NREG_W-1:0] addr;
    logic [T_W-1:0]    tnew;
  } entry_t;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Hazard check for one D-stage source operand against the E/M/W entries:
// produces that source's stall term and its forwarding select.
module hazard_src_check
  import hazard_scoreboard_pkg::*;
(
  input  logic [NREG_W-1:0]  src_addr,
  input  logic [T_W-1:0]     tuse,
  input  logic [ENTRY_W-1:0] entry_e,
  input  logic [ENTRY_W-1:0] entry_m,
  input  logic [ENTRY_W-1:0] entry_w,
  output logic               stall,
  output logic [1:0]         sel
);

  entry_t e, m, w;
  logic   match_e, match_m, match_w;

  assign e = entry_e;
  assign m = entry_m;
  assign w = entry_w;

  assign match_e = (src_addr != '0) && (e.addr == src_addr);
  assign match_m = (src_addr != '0) && (m.addr == src_addr);
  assign match_w = (src_addr != '0) && (w.addr == src_addr);

  assign stall = (match_e && (e.tnew > tuse)) || (match_m && (m.tnew > tuse));

  // The youngest match decides: a producer still in flight blocks older copies.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = FWD_RF;
    if (match_e)      sel = (e.tnew == '0) ? FWD_E : FWD_RF;
    else if (match_m) sel = (m.tnew == '0) ? FWD_M : FWD_RF;
    else if (match_w) sel = (w.tnew == '0) ? FWD_W : FWD_RF;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard controller: E/M/W destination/Tnew tracking,
// stall and D-stage forwarding selects. HAZARD_PERF_CNT_EN builds stall_cnt.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NREG_W-1:0] d_a1,
  input  logic [NREG_W-1:0] d_a2,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic [NREG_W-1:0] d_waddr,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic [31:0]       stall_cnt
);

  entry_t e_q, m_q, w_q;
  logic   stall_rs, stall_rt;

  // NOTE: state registers use non-blocking assignments so every entry
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (flush) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q <= '{addr: m_q.addr, tnew: sat_dec(m_q.tnew)};
      m_q <= '{addr: e_q.addr, tnew: sat_dec(e_q.tnew)};
      e_q <= stall ? entry_t'('0) : '{addr: d_waddr, tnew: sat_dec(d_tnew)};
    end
  end

  hazard_src_check u_rs_check (
    .src_addr (d_a1),
    .tuse     (d_tuse_rs),
    .entry_e  (e_q),
    .entry_m  (m_q),
    .entry_w  (w_q),
    .stall    (stall_rs),
    .sel      (fwd_rs_sel)
  );

  hazard_src_check u_rt_check (
    .src_addr (d_a2),
    .tuse     (d_tuse_rt),
    .entry_e  (e_q),
    .entry_m  (m_q),
    .entry_w  (w_q),
    .stall    (stall_rt),
    .sel      (fwd_rt_sel)
  );

  assign stall = stall_rs | stall_rt;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Flush cycles are not real stalls: the stalled instruction is killed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                stall_cnt_q <= '0;
    else if (stall && !flush) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; stall_cnt expectations
// follow HAZARD_PERF_CNT_EN.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_a1, d_a2, d_waddr;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_a1       (d_a1),
    .d_a2       (d_a2),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_waddr    (d_waddr),
    .d_tnew     (d_tnew),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_stall, input logic [1:0] exp_rs,
                           input logic [1:0] exp_rt, input int exp_cnt);
    check({tag, " stall"}, {31'd0, stall}, {31'd0, exp_stall});
    check({tag, " rs_sel"}, {30'd0, fwd_rs_sel}, {30'd0, exp_rs});
    check({tag, " rt_sel"}, {30'd0, fwd_rt_sel}, {30'd0, exp_rt});
    check({tag, " cnt"}, stall_cnt, CNT_EN ? 32'(exp_cnt) : 32'd0);
  endtask

  task automatic set_d(input logic [4:0] a1, input logic [1:0] tu_rs, input logic [4:0] a2,
                       input logic [1:0] tu_rt, input logic [4:0] wa, input logic [1:0] tn);
    d_a1 = a1; d_tuse_rs = tu_rs; d_a2 = a2; d_tuse_rt = tu_rt; d_waddr = wa; d_tnew = tn;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    #10;
    check_all("reset", 1'b0, 2'd0, 2'd0, 0);
    reset = 1'b0;
    tick();

    set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0);
    check_all("empty", 1'b0, 2'd0, 2'd0, 0);

    // load $8, then dependent consumer with tuse=1
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd3);
    tick();
    set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0);
    check_all("load_use_e", 1'b1, 2'd0, 2'd0, 0);
    tick();
    check_all("load_use_m", 1'b0, 2'd0, 2'd0, 1);
    tick();
    check_all("load_use_w", 1'b0, 2'd3, 2'd0, 1);
    idle(3);

    // jal $31 then jr $31 (also on rt)
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd1);
    tick();
    set_d(5'd31, 2'd0, 5'd31, 2'd0, 5'd0, 2'd0);
    check_all("jal_jr", 1'b0, 2'd1, 2'd1, 1);
    idle(3);

    // load $5 then branch on rt with tuse=0: two stall cycles
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd3);
    tick();
    set_d(5'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0);
    check_all("ld_br_1", 1'b1, 2'd0, 2'd0, 1);
    tick();
    check_all("ld_br_2", 1'b1, 2'd0, 2'd0, 2);
    tick();
    check_all("ld_br_3", 1'b0, 2'd0, 2'd3, 3);
    idle(3);

    // producer tnew=2, one unrelated instruction, then M forwarding
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd2);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    tick();
    set_d(5'd10, 2'd1, 5'd10, 2'd0, 5'd0, 2'd0);
    check_all("fwd_m", 1'b0, 2'd2, 2'd2, 3);
    idle(3);

    // E and M both hold $12 ready: E wins
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd1);
    tick();
    tick();
    set_d(5'd12, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    check_all("prio_e_m", 1'b0, 2'd1, 2'd0, 3);

    // younger load into $12 blocks the older ready copies
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd3);
    tick();
    set_d(5'd12, 2'd3, 5'd12, 2'd2, 5'd0, 2'd0);
    check_all("block_nostall", 1'b0, 2'd0, 2'd0, 3);
    set_d(5'd12, 2'd3, 5'd12, 2'd1, 5'd0, 2'd0);
    check_all("block_stall", 1'b1, 2'd0, 2'd0, 3);

    // flush while stalled: entries cleared, cycle not counted
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_all("after_flush", 1'b0, 2'd0, 2'd0, 3);

    // addr 0 is never a hazard even with a pending tnew
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    check_all("zero_addr", 1'b0, 2'd0, 2'd0, 3);
    idle(3);

    // async reset in the middle of a stall
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd3);
    tick();
    set_d(5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    check_all("pre_reset", 1'b1, 2'd0, 2'd0, 3);
    #2;
    reset = 1'b1;
    #1;
    check_all("mid_reset", 1'b0, 2'd0, 2'd0, 0);
    tick();
    reset = 1'b0;
    tick();
    check_all("post_reset", 1'b0, 2'd0, 2'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
